// File: rtl/aes_pkg.sv
// Shared AES constants, key-expansion FSM state type and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NUM_RODADAS     = 10;
  localparam int unsigned LARGURA_PALAVRA = 32;
  localparam int unsigned LARGURA_CHAVE   = 128;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ENTREGA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as inverse (a^254, square-and-multiply) followed by the affine map; 0 maps to 0 before affine.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rodada);
    logic [7:0] r;
    case (rodada)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/expansao_chave_if.sv
// Round-key delivery bus: key, index and valid towards the round datapath, ready back.
interface expansao_chave_if;
  logic [aes_pkg::LARGURA_CHAVE-1:0] chave_rodada;
  logic [3:0]                        indice_rodada;
  logic                              valido;
  logic                              pronto;

  modport master (output chave_rodada, output indice_rodada, output valido, input pronto);
  modport slave  (input chave_rodada, input indice_rodada, input valido, output pronto);
endinterface

// File: rtl/expansao_chave_funcaog.sv
// AES key-schedule g function: RotWord, SubWord, then Rcon xor into the top byte.
module funcaoG
  import aes_pkg::*;
(
  input  logic [LARGURA_PALAVRA-1:0] palavra,
  input  logic [3:0]                 rodada,
  output logic [LARGURA_PALAVRA-1:0] resultado
);

  logic [LARGURA_PALAVRA-1:0] rot;
  logic [LARGURA_PALAVRA-1:0] sub;

  assign rot = {palavra[23:0], palavra[31:24]};

  always_comb begin
    sub = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      sub[b*8 +: 8] = sbox(rot[b*8 +: 8]);
    end
  end

  assign resultado = sub ^ {rcon(rodada), 24'h000000};

endmodule

// File: rtl/expansao_chave.sv
// Iterative AES-128 key-expansion sequencer, one round key per accepted handshake.
// Optional round-key store enabled by defining ARMAZENA_CHAVES_EN.
module expansao_chave
  import aes_pkg::*;
#(
  parameter int unsigned NUM_RODADAS = aes_pkg::NUM_RODADAS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inicio,
  input  logic [LARGURA_CHAVE-1:0] chave,
  expansao_chave_if.master         rodada_if,
  output logic                     ocupado,
  output logic                     fim,
  input  logic [3:0]               leitura_indice,
  output logic [LARGURA_CHAVE-1:0] leitura_chave
);

  estado_t                    estado;
  logic [LARGURA_CHAVE-1:0]   chave_r;
  logic [3:0]                 indice_r;
  logic                       valido_r;
  logic [LARGURA_PALAVRA-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [LARGURA_CHAVE-1:0]   proxima;
  logic                       aceite, ultimo, carrega, avanca;

  assign {w0, w1, w2, w3} = chave_r;

  funcaoG u_funcaog (
    .palavra   (w3),
    .rodada    (indice_r),
    .resultado (t)
  );

  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign proxima = {n0, n1, n2, n3};

  assign aceite  = (estado == ENTREGA) && valido_r && rodada_if.pronto;
  assign ultimo  = (indice_r == 4'(NUM_RODADAS));
  assign carrega = (estado == OCIOSO) && inicio;
  assign avanca  = aceite && !ultimo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      chave_r  <= '0;
      indice_r <= '0;
      valido_r <= 1'b0;
      ocupado  <= 1'b0;
      fim      <= 1'b0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          fim <= 1'b0;
          if (carrega) begin
            chave_r  <= chave;
            indice_r <= '0;
            valido_r <= 1'b1;
            ocupado  <= 1'b1;
            estado   <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (avanca) begin
            chave_r  <= proxima;
            indice_r <= indice_r + 4'd1;
          end else if (aceite) begin
            valido_r <= 1'b0;
            fim      <= 1'b1;
            estado   <= FIM;
          end
        end
        FIM: begin
          fim     <= 1'b0;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign rodada_if.chave_rodada  = chave_r;
  assign rodada_if.indice_rodada = indice_r;
  assign rodada_if.valido        = valido_r;

`ifdef ARMAZENA_CHAVES_EN
  logic [LARGURA_CHAVE-1:0] banco [0:NUM_RODADAS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= NUM_RODADAS; i++) banco[i] <= '0;
    end else if (carrega) begin
      banco[0] <= chave;
    end else if (avanca) begin
      banco[indice_r + 4'd1] <= proxima;
    end
  end

  assign leitura_chave = (leitura_indice <= 4'(NUM_RODADAS)) ? banco[leitura_indice] : '0;
`else
  logic unused_leitura;
  assign unused_leitura = ^leitura_indice;
  assign leitura_chave  = '0;
`endif

endmodule

// File: tb/tb_expansao_chave.sv
// Scoreboard bench for expansao_chave: a table-based key-schedule model feeds an expected-key queue.
module tb_expansao_chave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inicio;
  logic [127:0] chave;
  logic         ocupado;
  logic         fim;
  logic [3:0]   leitura_indice;
  logic [127:0] leitura_chave;

  always #5 clk = ~clk;

  expansao_chave_if bus ();

  expansao_chave dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inicio         (inicio),
    .chave          (chave),
    .rodada_if      (bus),
    .ocupado        (ocupado),
    .fim            (fim),
    .leitura_indice (leitura_indice),
    .leitura_chave  (leitura_chave)
  );

  localparam logic [127:0] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_FIPS2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K_FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ZERO1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K_ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] k;
  } item_t;

  item_t        fila[$];
  logic [127:0] obs_k [0:10];
  logic [7:0]   tab_sbox [0:255];
  logic [7:0]   tab_exp  [0:254];
  int           tab_log  [0:255];
  logic [7:0]   tab_rcon [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  int vetores = 0;
  int erros   = 0;

  task automatic confere(input string tag, input logic [127:0] obs, input logic [127:0] esp);
    vetores++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  // S-box built from exp/log tables over generator 3.
  task automatic monta_sbox();
    logic [7:0] x, inv, r;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      tab_exp[i] = x;
      tab_log[x] = i;
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : tab_exp[(255 - tab_log[a]) % 255];
      r   = inv;
      tab_sbox[a] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] modelo(input logic [127:0] k, input int r);
    logic [31:0] w [0:3];
    logic [31:0] g;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    g = {tab_sbox[w[3][23:16]] ^ tab_rcon[r], tab_sbox[w[3][15:8]], tab_sbox[w[3][7:0]], tab_sbox[w[3][31:24]]};
    w[0] = w[0] ^ g;
    for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic expande(input logic [127:0] k, input bit bp, input bit reinicia);
    logic [127:0] m;
    logic [127:0] hold_k;
    logic [3:0]   hold_i;
    bit           hold;
    bit           p;
    int           cnt;
    item_t        e;
    m    = k;
    hold = 1'b0;
    cnt  = 0;
    for (int r = 0; r <= 10; r++) begin
      fila.push_back('{4'(r), m});
      if (r < 10) m = modelo(m, r);
    end
    confere("idle_valido", 128'(bus.valido), 128'd0);
    inicio = 1'b1;
    chave  = k;
    @(negedge clk);
    inicio = 1'b0;
    chave  = ~k;
    for (int c = 0; c < 400 && cnt < 11; c++) begin
      if (hold) begin
        confere("hold_key", bus.chave_rodada, hold_k);
        confere("hold_idx", 128'(bus.indice_rodada), 128'(hold_i));
      end
      confere("valido", 128'(bus.valido), 128'd1);
      confere("ocupado", 128'(ocupado), 128'd1);
      p = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pronto = p;
      if (reinicia && bus.indice_rodada == 4'd4) begin
        inicio = 1'b1;
        chave  = '0;
      end else begin
        inicio = 1'b0;
      end
      if (p) begin
        e = fila.pop_front();
        confere("idx", 128'(bus.indice_rodada), 128'(e.idx));
        confere("key", bus.chave_rodada, e.k);
        obs_k[cnt] = bus.chave_rodada;
        cnt++;
        hold = 1'b0;
      end else begin
        hold   = 1'b1;
        hold_k = bus.chave_rodada;
        hold_i = bus.indice_rodada;
      end
      @(negedge clk);
    end
    inicio = 1'b0;
    if (cnt < 11) confere("timeout", 128'(cnt), 128'd11);
    fila.delete();
    confere("fim_pulse", 128'(fim), 128'd1);
    confere("fim_valido", 128'(bus.valido), 128'd0);
    confere("fim_ocupado", 128'(ocupado), 128'd1);
    @(negedge clk);
    confere("pos_fim", 128'(fim), 128'd0);
    confere("pos_ocupado", 128'(ocupado), 128'd0);
    confere("retem_key", bus.chave_rodada, m);
    confere("retem_idx", 128'(bus.indice_rodada), 128'd10);
  endtask

  initial begin
    rst_n          = 1'b0;
    inicio         = 1'b0;
    chave          = '0;
    bus.pronto     = 1'b0;
    leitura_indice = '0;
    monta_sbox();
    repeat (2) @(negedge clk);
    confere("rst_key", bus.chave_rodada, 128'd0);
    confere("rst_idx", 128'(bus.indice_rodada), 128'd0);
    confere("rst_valido", 128'(bus.valido), 128'd0);
    confere("rst_ocupado", 128'(ocupado), 128'd0);
    confere("rst_fim", 128'(fim), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    expande(K_FIPS, 1'b0, 1'b0);
    confere("fips_idx0", obs_k[0], K_FIPS);
    confere("fips_idx1", obs_k[1], K_FIPS1);
    confere("fips_idx2", obs_k[2], K_FIPS2);
    confere("fips_idx10", obs_k[10], K_FIPS10);

`ifdef ARMAZENA_CHAVES_EN
    leitura_indice = 4'd0;  #1 confere("rd0", leitura_chave, K_FIPS);
    leitura_indice = 4'd1;  #1 confere("rd1", leitura_chave, K_FIPS1);
    leitura_indice = 4'd10; #1 confere("rd10", leitura_chave, K_FIPS10);
    leitura_indice = 4'd12; #1 confere("rd12", leitura_chave, 128'd0);
`else
    for (int i = 0; i < 16; i += 5) begin
      leitura_indice = 4'(i);
      #1 confere("rd_off", leitura_chave, 128'd0);
    end
`endif
    @(negedge clk);

    expande(K_FIPS, 1'b1, 1'b0);
    expande(K_FIPS, 1'b0, 1'b1);
    confere("restart_idx10", obs_k[10], K_FIPS10);
    expande(128'd0, 1'b0, 1'b0);
    confere("zero_idx1", obs_k[1], K_ZERO1);
    confere("zero_idx10", obs_k[10], K_ZERO10);

    inicio = 1'b1;
    chave  = K_FIPS;
    @(negedge clk);
    inicio     = 1'b0;
    bus.pronto = 1'b1;
    repeat (3) @(negedge clk);
    bus.pronto = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    confere("arst_key", bus.chave_rodada, 128'd0);
    confere("arst_idx", 128'(bus.indice_rodada), 128'd0);
    confere("arst_valido", 128'(bus.valido), 128'd0);
    confere("arst_ocupado", 128'(ocupado), 128'd0);
    confere("arst_fim", 128'(fim), 128'd0);
`ifdef ARMAZENA_CHAVES_EN
    leitura_indice = 4'd1;
    #1 confere("arst_rd1", leitura_chave, 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expande(K_FIPS, 1'b0, 1'b0);
    confere("rerun_idx0", obs_k[0], K_FIPS);

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/expansao_chave.md
Name: expansao_chave

Overview:
- Iterative AES-128 key-expansion sequencer; sits directly upstream of the round datapath.
- Loads a 128-bit cipher key and produces round keys 0..10, one per accepted handshake.
- Each next round key is computed from the current one using the existing funcaoG instance, which applies RotWord, SubWord and Rcon.
- Downstream may stall round-key delivery with a valid/ready handshake.

Parameters:
- NUM_RODADAS, 10, index of the last round key produced; fixed for AES-128 and not meant to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inicio  in  1  start pulse; sampled only in OCIOSO
- chave  in  128  cipher key; w0 = chave[127:96], w3 = chave[31:0]
- chave_rodada  out  128  current round key, same word order as chave
- indice_rodada  out  4  index (0..10) of chave_rodada
- valido  out  1  chave_rodada/indice_rodada are valid
- pronto  in  1  downstream accepts when valido && pronto
- ocupado  out  1  high in every state except OCIOSO
- fim  out  1  one-cycle pulse after round key 10 is accepted
- leitura_indice  in  4  stored-key read index (optional feature)
- leitura_chave  out  128  stored-key read data (optional feature)

Behaviour:
- Reset (async, rst_n=0): state OCIOSO; chave_rodada=0, indice_rodada=0, valido=0, ocupado=0, fim=0. Reset asserted mid-expansion aborts immediately; no partial output survives.
- FSM states: OCIOSO, ENTREGA, FIM.
- OCIOSO:
  - On inicio=1 at a clock edge: register chave as round key 0, indice_rodada=0, go to ENTREGA.
  - valido=1 on the next cycle, so latency from start to first valid is 1 cycle.
- ENTREGA:
  - valido=1. Outputs hold stable while pronto=0; no spontaneous change.
  - Handshake with indice<10: register the next key combinationally derived from the current one and increment indice. valido stays 1, giving a new key every cycle under pronto=1.
  - Next-key derivation, with current words w0..w3 and t = funcaoG(palavra=w3, rodada=indice):
    - n0 = w0^t
    - n1 = w1^n0
    - n2 = w2^n1
    - n3 = w3^n2
  - rodada fed to funcaoG is the current indice (0..9), which selects Rcon 01,02,..,36.
  - Handshake with indice=10: valido→0, go to FIM.
- FIM:
  - fim=1 for exactly one cycle, then OCIOSO.
  - chave_rodada retains round key 10 until the next start.
- inicio while ocupado=1 is ignored; no restart and no corruption.
- inicio and the final handshake never conflict, because inicio is only sampled in OCIOSO.
- indice_rodada never exceeds 10, and funcaoG is never driven with rodada>9 during a transition.
- Full expansion with pronto held 1 takes 11 consecutive valid cycles, then the fim cycle.

Optional Feature:
- Macro: ARMAZENA_CHAVES_EN.
- Defined:
  - Every round key is written into an internal 11x128 register array as it is registered.
  - leitura_chave = array[leitura_indice], combinational.
  - Indices 11..15 read 0.
  - The array is cleared by reset and retained across later idle periods.
  - A new start overwrites entries progressively.
- Undefined:
  - No array is built; leitura_chave is tied to 0.
  - leitura_indice is unused.

Decomposition:
- Shared package aes_pkg holds:
  - constants NUM_RODADAS=10, LARGURA_PALAVRA=32, LARGURA_CHAVE=128
  - the FSM state typedef (OCIOSO, ENTREGA, FIM)
- Sub-module: the existing funcaoG, instantiated once, driven with w3 and indice_rodada.
- The next-key XOR chain stays inline; no further sub-modules.

Test Plan:
- Reset: assert rst_n=0 mid-ENTREGA → all outputs 0 immediately (async), state OCIOSO. Release, then start again → round key 0 reappears.
- FIPS-197 vector, pronto=1: chave=2b7e151628aed2a6abf7158809cf4f3c →
  - idx0 = same key
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx2 = f2c295f27a96b9435935807a7359f67f
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 consecutive valid cycles, then fim for 1 cycle.
- Backpressure: same key, pronto toggled pseudo-randomly → identical 11-key sequence; outputs stable during every pronto=0 cycle; no skipped or duplicated index.
- Ignored restart: pulse inicio with chave=0 at idx 4 → sequence continues unchanged to d014f9a8…; ocupado stays 1 until after fim.
- Zero key: chave=0 → idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- ARMAZENA_CHAVES_EN: after the FIPS run, read indices 0, 1, 10 → the vectors above; index 12 reads 0. Without the macro, leitura_chave=0 for all indices.
